int_accept_scheduler: RTL
=========================

# int_accept_scheduler

Sequences interrupt acceptance for the interrupt controller. Takes the 56 per-source pending flags and their 3-bit IPR priority fields (14 registers × 4 fields), arbitrates for the highest-priority eligible source, and presents one request (level + vector) to the CPU. It holds that request until acknowledge, then pulses a clear to the winning source's pending flag. It sits between the IPR register file / max-priority comparator path and the CPU interrupt interface.

## Interface
- NUM_SRC, 56, number of interrupt sources (source i = IPR register i/4, field i%4; field 0 = bits 14:12 … field 3 = bits 2:0)
- PRI_W, 3, priority field width
- VEC_W, 6, vector width, ≥ clog2(NUM_SRC)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- ipr_pri  in  NUM_SRC*PRI_W  flattened priorities, source i at [i*PRI_W +: PRI_W]; 0 = disabled
- int_pend  in  NUM_SRC  level pending flags from sources
- cpu_mask  in  PRI_W  CPU interrupt mask level
- irq_ack  in  1  CPU acknowledge, one-cycle pulse
- irq_req  out  1  interrupt request to CPU
- irq_level  out  PRI_W  priority of the presented source
- irq_vec  out  VEC_W  index of the presented source
- pend_clr  out  NUM_SRC  one-hot pending clear, one-cycle pulse
- busy  out  1  high in any state other than IDLE

## Operation
- Eligible(i) = int_pend[i] && ipr_pri[i] != 0 && ipr_pri[i] > cpu_mask. A level equal to the mask is not eligible.
- Winner = eligible source with the maximum priority. A tie goes to the lowest index.
- FSM states: IDLE, ARB, REQ, DONE.
- IDLE:
  - any eligible → ARB.
  - otherwise stay in IDLE.
- ARB:
  - registers winner index and level into irq_vec/irq_level.
  - if no source is still eligible → IDLE, with outputs unchanged.
  - otherwise → REQ.
- REQ:
  - irq_req = 1; irq_level/irq_vec held stable.
  - irq_ack = 1 → DONE.
  - the latched source is no longer eligible (pend drop, priority rewrite, or mask raise) and irq_ack = 0 → IDLE. This withdrawal drops irq_req with no clear.
  - ack and withdrawal in the same cycle: ack wins.
- DONE:
  - pend_clr[irq_vec] = 1 for exactly one cycle; irq_req = 0 → IDLE.
- irq_ack outside REQ is ignored.
- pend_clr is never multi-hot.

## Timing
- Reset values: irq_req 0, irq_level 0, irq_vec 0, pend_clr all 0, busy 0, state IDLE.
- Eligible at cycle N in IDLE → ARB at N+1 → irq_req = 1 at N+2. Latency is 2 cycles.
- irq_ack at cycle M while in REQ → irq_req = 0 and pend_clr pulse at M+1 → IDLE at M+2.
- Next request earliest at M+4. Minimum 1-cycle irq_req low gap between requests.
- irq_level/irq_vec keep their last value when irq_req = 0.
- rst asserted in any state → next cycle all outputs at reset values. A request in flight is lost and no clear is issued.
- Arbitration is purely combinational over sources and registered only at ARB. One 56-way compare stage per cycle.

## Configuration
- INT_PREEMPT_EN defined:
  - in REQ, if any eligible source has priority strictly greater than irq_level, irq_level/irq_vec update to the new winner on the next edge.
  - irq_req stays high and no clear is issued for the displaced source.
  - if ack and a preempting source arrive in the same cycle, ack wins.
- INT_PREEMPT_EN undefined:
  - the latched request is fixed until ack or withdrawal.
  - higher-priority arrivals wait for the next IDLE.

## Test plan
- Reset mid-REQ: src 5 at pri 3 reaches REQ, rst pulsed → next cycle irq_req = 0, vec 0, pend_clr 0, busy 0.
- Single source: mask 0, src 9 pri 4 pending at cycle N → irq_req = 1, level 4, vec 9 at N+2. Ack at M → pend_clr = 1 << 9 at M+1, irq_req = 0 at M+1.
- Tie and mask:
  - src 3 and src 40 both pri 6, mask 5 → vec 3, level 6.
  - mask 6 → no request, busy returns 0.
- Withdrawal: in REQ with vec 12, int_pend[12] drops with no ack → irq_req = 0 next cycle, no pend_clr pulse, back to IDLE.
- Preemption: vec 2 at pri 2 in REQ, src 50 goes pending at pri 7.
  - with INT_PREEMPT_EN: level 7, vec 50 next cycle, irq_req never drops.
  - without INT_PREEMPT_EN: stays vec 2 until ack, then vec 50 requested 4 cycles after the ack.
- Ack racing withdrawal: irq_ack and int_pend drop in the same REQ cycle → pend_clr pulse issued. A stray ack in IDLE → no effect.

Source files
------------

// File: rtl/int_accept_scheduler.sv
// Interrupt acceptance sequencer: picks the highest-priority eligible source, holds the CPU request until ack, then pulses its pending clear.
// Optional feature: define INT_PREEMPT_EN to let a strictly higher-priority source replace the request while it is held.
module int_accept_scheduler #(
  parameter int NUM_SRC = 56,
  parameter int PRI_W   = 3,
  parameter int VEC_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*PRI_W-1:0] ipr_pri,
  input  logic [NUM_SRC-1:0]       int_pend,
  input  logic [PRI_W-1:0]         cpu_mask,
  input  logic                     irq_ack,
  output logic                     irq_req,
  output logic [PRI_W-1:0]         irq_level,
  output logic [VEC_W-1:0]         irq_vec,
  output logic [NUM_SRC-1:0]       pend_clr,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  // Handshake: irq_req is held high from REQ until irq_ack is seen high on a rising edge;
  // irq_ack is a single-cycle pulse and is only honoured while irq_req is high.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARB = 2'd1, S_REQ = 2'd2, S_DONE = 2'd3} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PRI_W-1:0]   r_level;
  logic [VEC_W-1:0]   r_vec;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_any;
  logic [PRI_W-1:0]   w_win_pri;
  logic [VEC_W-1:0]   w_win_vec;
  logic               w_lat_elig;
  logic               w_load;
  logic               w_preempt;

  // A level equal to the mask is masked; priority 0 means disabled.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_elig[i] = int_pend[i] && (ipr_pri[i*PRI_W +: PRI_W] != '0) &&
                  (ipr_pri[i*PRI_W +: PRI_W] > cpu_mask);
    end
  end

  // Strictly-greater update while scanning upward keeps the lowest index on ties.
  always_comb begin
    w_any     = 1'b0;
    w_win_pri = '0;
    w_win_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_elig[i] && (ipr_pri[i*PRI_W +: PRI_W] > w_win_pri)) begin
        w_any     = 1'b1;
        w_win_pri = ipr_pri[i*PRI_W +: PRI_W];
        w_win_vec = VEC_W'(i);
      end
    end
  end

  assign w_lat_elig = w_elig[r_vec];

`ifdef INT_PREEMPT_EN
  assign w_preempt = (r_state == S_REQ) && !irq_ack && w_any && (w_win_pri > r_level);
`else
  assign w_preempt = 1'b0;
`endif

  assign w_load = ((r_state == S_ARB) && w_any) || w_preempt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_ARB;
      S_ARB:  w_next = w_any ? S_REQ : S_IDLE;
      S_REQ: begin
        if (irq_ack)          w_next = S_DONE;
        else if (w_preempt)   w_next = S_REQ;
        else if (!w_lat_elig) w_next = S_IDLE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
      r_vec   <= '0;
    end else if (w_load) begin
      r_level <= w_win_pri;
      r_vec   <= w_win_vec;
    end
  end

  always_comb begin
    irq_req  = 1'b0;
    busy     = 1'b1;
    pend_clr = '0;
    case (r_state)
      S_IDLE: busy = 1'b0;
      S_REQ:  irq_req = 1'b1;
      S_DONE: pend_clr = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_vec;
      default: ;
    endcase
  end

  assign irq_level = r_level;
  assign irq_vec   = r_vec;
  assign dbg_state = r_state;

endmodule
